cpu_blitter_sequencer: RTL and testbench
========================================

# cpu_blitter_sequencer

Graphics blitter sequencer on the Kangaroo CPU board. It sits directly downstream of the game microprocessor address decoder. It latches the source, destination and size registers through the decoder strobes `RDL_AL`, `RDH_AL`, `WRL_AL`, `WRH_AL`, `XYL_AL` and `XYH_AL`. A write to `XYH_AL` starts a rectangular copy from graphics ROM into video RAM, one byte every two clocks.

## Interface
Parameters:
- `ROW_STRIDE`, default 256: destination address increment between rows (16-bit add, wraps).

Ports:
- `CPU_CLOCK`  in  1  single block clock. It is the same clock that drives the Z80.
- `FPGA_RESET`  in  1  synchronous, active-high reset.
- `DB`  in  8  buffered CPU data bus. Sampled on an accepted register write.
- `RDL_AL`, `RDH_AL`  in  1  active-low strobes: source address low/high byte.
- `WRL_AL`, `WRH_AL`  in  1  active-low strobes: destination address low/high byte.
- `XYL_AL`, `XYH_AL`  in  1  active-low strobes: width-1 / height-1. `XYH_AL` also starts the blit.
- `GFX_ADDR`  out  16  graphics ROM read address.
- `GFX_RD`  out  1  ROM read request. Data is valid on `GFX_DATA` the following cycle.
- `GFX_DATA`  in  8  graphics ROM read data.
- `VRAM_ADDR`  out  16  video RAM write address.
- `VRAM_DATA`  out  8  video RAM write data.
- `VRAM_WE`  out  1  active-high video RAM write enable, one cycle per byte.
- `BLIT_BUSY`  out  1  high while a blit is in progress.
- `WAIT_AL`  out  1  active-low Z80 wait request. Tied to 1 unless `BLIT_WAIT_EN` is defined.

## Operation
Strobe capture:
- Each strobe has an armed flag.
- A write is accepted when the strobe is sampled low, its flag is armed, and the sequencer is IDLE. Accepting clears the flag; the strobe sampled high re-arms it.
- An accepted write loads `DB` into the register that strobe selects.
- A strobe low while BUSY disarms the flag with no write. Without the macro, that write is therefore lost.

Registers (all 8-bit, reset to 0):
- `SRC[15:0]` from RDH:RDL.
- `DST[15:0]` from WRH:WRL.
- `W` from XYL.
- `H` from XYH.
- Copy size is (W+1) × (H+1) bytes: 0 means 1, 255 means 256.

State machine, states IDLE, READ, WRITE:
- **Trigger (IDLE → READ):** an accepted XYH write loads `H` and enters READ. It initialises col=0, row=0, src_ptr=SRC, row_base=DST, dst_ptr=DST.
- **READ:** `GFX_RD`=1, `GFX_ADDR`=src_ptr. Next state is WRITE.
- **WRITE:** `VRAM_WE`=1, `VRAM_ADDR`=dst_ptr, `VRAM_DATA`=`GFX_DATA`. Then src_ptr+=1 (16-bit wrap), and:
  - if col≠W: col+=1, dst_ptr+=1, go to READ;
  - else if row≠H: col=0, row+=1, row_base+=`ROW_STRIDE`, dst_ptr=new row_base, go to READ;
  - else go to IDLE.
- **Source addressing:** src_ptr is linear across rows; it does not jump per row.
- **Register stability:** `SRC`, `DST` and `W` are not modified by a blit, so a second `XYH` write repeats the same copy.

Reset:
- `FPGA_RESET` at any cycle forces IDLE and clears all registers, pointers and armed flags.
- Reset clears all outputs to 0, except `WAIT_AL`=1.
- Reset mid-blit aborts the blit with no further `VRAM_WE`.

## Timing
- An `XYH_AL` low sample accepted at cycle t gives `BLIT_BUSY`=1 and `GFX_RD`=1 at t+1, and the first `VRAM_WE` at t+2.
- A blit lasts exactly 2·(W+1)·(H+1) cycles of `BLIT_BUSY`. `BLIT_BUSY` drops the cycle after the last `VRAM_WE`.
- A new trigger is accepted no earlier than the first IDLE cycle.
- `GFX_RD` and `VRAM_WE` are never high in the same cycle.
- All outputs are registered. Address and data outputs are 0 when the corresponding enable is low.

## Configuration
`BLIT_WAIT_EN` defined:
- `WAIT_AL` = 0 combinationally while `BLIT_BUSY` and any of the six strobes is low.
- The Z80 stalls, the strobe stays low, and the flag stays armed. The write is accepted on the first IDLE cycle.
- With the macro, busy-time strobes do not disarm the flag.

`BLIT_WAIT_EN` undefined:
- `WAIT_AL` is tied to 1.
- Busy-time writes are dropped as described above.

## Structure
- Package `cpu_blitter_pkg` holds:
  - the state enum `blit_state_t` (IDLE, READ, WRITE);
  - the register-select enum for the six strobes;
  - the reset constants.
- One sub-module, `blit_strobe_capture`: a per-strobe armed flag plus acceptance qualifier, instantiated six times.

## Test plan
- **Basic blit:** SRC=0x1000, DST=0x0000, W=1, H=1, trigger → writes to 0x0000, 0x0001, 0x0100, 0x0101 with ROM data from 0x1000–0x1003; `BLIT_BUSY` high exactly 8 cycles.
- **Minimum size:** W=0, H=0 → exactly one `VRAM_WE`, at t+2; `BLIT_BUSY` high 2 cycles.
- **Wrap:** SRC=0xFFFF, DST=0xFFFF, W=1, H=0 → reads 0xFFFF then 0x0000; writes 0xFFFF then 0x0000.
- **Busy-time write, macro off:** `WRL_AL` pulsed with 0x55 mid-blit → `DST` unchanged, `WAIT_AL` stays 1.
- **Busy-time write, macro on:** same pulse held low → `WAIT_AL`=0 until IDLE; `DST` low byte = 0x55 one cycle after `BLIT_BUSY` falls.
- **Reset mid-blit:** `FPGA_RESET` during a W=3, H=3 blit → next cycle IDLE, `VRAM_WE`=0, registers 0; a new trigger then runs normally.

Source files
------------

// File: rtl/cpu_blitter_pkg.sv
// Shared types and reset constants for the Kangaroo blitter sequencer.
package cpu_blitter_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2
    } blit_state_t;

    // Bit positions of the six decoder strobes in the packed strobe vector.
    typedef enum logic [2:0] {
        SEL_RDL = 3'd0,
        SEL_RDH = 3'd1,
        SEL_WRL = 3'd2,
        SEL_WRH = 3'd3,
        SEL_XYL = 3'd4,
        SEL_XYH = 3'd5
    } reg_sel_t;

    localparam int          NUM_STROBES = 6;
    localparam logic [7:0]  RST_BYTE    = 8'h00;
    localparam logic [15:0] RST_ADDR    = 16'h0000;
    localparam logic        RST_WAIT_AL = 1'b1;

endpackage

// File: rtl/blit_strobe_capture.sv
// One decoder strobe: armed flag plus write-acceptance qualifier (one accept per low pulse).
module blit_strobe_capture #(
    parameter bit DISARM_ON_BUSY = 1'b1
) (
    input  logic i_clk,
    input  logic i_srst,
    input  logic i_strobe_al,
    input  logic i_idle,
    output logic o_accept
);

    logic r_armed;

    assign o_accept = ~i_strobe_al & r_armed & i_idle;

    // A busy-time low either consumes the pulse (write lost) or leaves it pending for IDLE.
    always_ff @(posedge i_clk) begin
        if (i_srst) begin
            r_armed <= 1'b0;
        end else if (i_strobe_al) begin
            r_armed <= 1'b1;
        end else if (o_accept) begin
            r_armed <= 1'b0;
        end else if (!i_idle && DISARM_ON_BUSY) begin
            r_armed <= 1'b0;
        end
    end

endmodule

// File: rtl/cpu_blitter_sequencer.sv
// Kangaroo blitter: strobe-loaded SRC/DST/W/H registers and a ROM-to-VRAM rectangle copy FSM.
// Optional macro BLIT_WAIT_EN: stall the Z80 via WAIT_AL instead of dropping busy-time writes.
module cpu_blitter_sequencer
    import cpu_blitter_pkg::*;
#(
    parameter logic [15:0] ROW_STRIDE = 16'd256
) (
    input  logic        CPU_CLOCK,
    input  logic        FPGA_RESET,
    input  logic [7:0]  DB,
    input  logic        RDL_AL,
    input  logic        RDH_AL,
    input  logic        WRL_AL,
    input  logic        WRH_AL,
    input  logic        XYL_AL,
    input  logic        XYH_AL,
    output logic [15:0] GFX_ADDR,
    output logic        GFX_RD,
    input  logic [7:0]  GFX_DATA,
    output logic [15:0] VRAM_ADDR,
    output logic [7:0]  VRAM_DATA,
    output logic        VRAM_WE,
    output logic        BLIT_BUSY,
    output logic        WAIT_AL
);

`ifdef BLIT_WAIT_EN
    localparam bit DISARM_ON_BUSY = 1'b0;
`else
    localparam bit DISARM_ON_BUSY = 1'b1;
`endif

    logic [NUM_STROBES-1:0] w_strobe_al;
    logic [NUM_STROBES-1:0] w_accept;
    logic                   w_idle;
    logic                   w_trigger;

    logic [15:0] r_src;
    logic [15:0] r_dst;
    logic [7:0]  r_w;
    logic [7:0]  r_h;

    blit_state_t r_state;
    blit_state_t w_state_next;

    logic [7:0]  r_col, w_col_next;
    logic [7:0]  r_row, w_row_next;
    logic [15:0] r_src_ptr, w_src_ptr_next;
    logic [15:0] r_dst_ptr, w_dst_ptr_next;
    logic [15:0] r_row_base, w_row_base_next;
    logic        w_last_col;
    logic        w_last_row;

    logic [15:0] r_gfx_addr, w_gfx_addr_next;
    logic        r_gfx_rd, w_gfx_rd_next;
    logic [15:0] r_vram_addr, w_vram_addr_next;
    logic        r_vram_we, w_vram_we_next;
    logic        r_busy, w_busy_next;

    assign w_strobe_al[SEL_RDL] = RDL_AL;
    assign w_strobe_al[SEL_RDH] = RDH_AL;
    assign w_strobe_al[SEL_WRL] = WRL_AL;
    assign w_strobe_al[SEL_WRH] = WRH_AL;
    assign w_strobe_al[SEL_XYL] = XYL_AL;
    assign w_strobe_al[SEL_XYH] = XYH_AL;

    assign w_idle    = (r_state == IDLE);
    assign w_trigger = w_accept[SEL_XYH];

    genvar gi;
    generate
        for (gi = 0; gi < NUM_STROBES; gi++) begin : g_cap
            blit_strobe_capture #(
                .DISARM_ON_BUSY(DISARM_ON_BUSY)
            ) u_cap (
                .i_clk      (CPU_CLOCK),
                .i_srst     (FPGA_RESET),
                .i_strobe_al(w_strobe_al[gi]),
                .i_idle     (w_idle),
                .o_accept   (w_accept[gi])
            );
        end
    endgenerate

    // Register file: writes only land while IDLE, so a blit never sees them change.
    always_ff @(posedge CPU_CLOCK) begin
        if (FPGA_RESET) begin
            r_src <= RST_ADDR;
            r_dst <= RST_ADDR;
            r_w   <= RST_BYTE;
            r_h   <= RST_BYTE;
        end else begin
            if (w_accept[SEL_RDL]) r_src[7:0]  <= DB;
            if (w_accept[SEL_RDH]) r_src[15:8] <= DB;
            if (w_accept[SEL_WRL]) r_dst[7:0]  <= DB;
            if (w_accept[SEL_WRH]) r_dst[15:8] <= DB;
            if (w_accept[SEL_XYL]) r_w         <= DB;
            if (w_accept[SEL_XYH]) r_h         <= DB;
        end
    end

    assign w_last_col = (r_col == r_w);
    assign w_last_row = (r_row == r_h);

    always_ff @(posedge CPU_CLOCK) begin
        if (FPGA_RESET) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (w_trigger) w_state_next = READ;
            READ:    w_state_next = WRITE;
            WRITE:   w_state_next = (w_last_col && w_last_row) ? IDLE : READ;
            default: w_state_next = IDLE;
        endcase
    end

    // Walk pointers: source is linear, destination steps by ROW_STRIDE at each row end.
    always_comb begin
        w_col_next      = r_col;
        w_row_next      = r_row;
        w_src_ptr_next  = r_src_ptr;
        w_dst_ptr_next  = r_dst_ptr;
        w_row_base_next = r_row_base;
        case (r_state)
            IDLE: begin
                if (w_trigger) begin
                    w_col_next      = 8'd0;
                    w_row_next      = 8'd0;
                    w_src_ptr_next  = r_src;
                    w_row_base_next = r_dst;
                    w_dst_ptr_next  = r_dst;
                end
            end
            WRITE: begin
                w_src_ptr_next = r_src_ptr + 16'd1;
                if (!w_last_col) begin
                    w_col_next     = r_col + 8'd1;
                    w_dst_ptr_next = r_dst_ptr + 16'd1;
                end else if (!w_last_row) begin
                    w_col_next      = 8'd0;
                    w_row_next      = r_row + 8'd1;
                    w_row_base_next = r_row_base + ROW_STRIDE;
                    w_dst_ptr_next  = r_row_base + ROW_STRIDE;
                end
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge CPU_CLOCK) begin
        if (FPGA_RESET) begin
            r_col      <= RST_BYTE;
            r_row      <= RST_BYTE;
            r_src_ptr  <= RST_ADDR;
            r_dst_ptr  <= RST_ADDR;
            r_row_base <= RST_ADDR;
        end else begin
            r_col      <= w_col_next;
            r_row      <= w_row_next;
            r_src_ptr  <= w_src_ptr_next;
            r_dst_ptr  <= w_dst_ptr_next;
            r_row_base <= w_row_base_next;
        end
    end

    // Outputs are decoded from the upcoming state so they line up with it after the edge.
    always_comb begin
        w_gfx_rd_next    = (w_state_next == READ);
        w_vram_we_next   = (w_state_next == WRITE);
        w_busy_next      = (w_state_next != IDLE);
        w_gfx_addr_next  = w_gfx_rd_next  ? w_src_ptr_next : RST_ADDR;
        w_vram_addr_next = w_vram_we_next ? w_dst_ptr_next : RST_ADDR;
    end

    always_ff @(posedge CPU_CLOCK) begin
        if (FPGA_RESET) begin
            r_gfx_addr  <= RST_ADDR;
            r_gfx_rd    <= 1'b0;
            r_vram_addr <= RST_ADDR;
            r_vram_we   <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_gfx_addr  <= w_gfx_addr_next;
            r_gfx_rd    <= w_gfx_rd_next;
            r_vram_addr <= w_vram_addr_next;
            r_vram_we   <= w_vram_we_next;
            r_busy      <= w_busy_next;
        end
    end

    assign GFX_ADDR  = r_gfx_addr;
    assign GFX_RD    = r_gfx_rd;
    assign VRAM_ADDR = r_vram_addr;
    assign VRAM_WE   = r_vram_we;
    assign BLIT_BUSY = r_busy;
    // ROM data arrives in the WRITE cycle itself, so it is gated straight through.
    assign VRAM_DATA = r_vram_we ? GFX_DATA : RST_BYTE;

`ifdef BLIT_WAIT_EN
    assign WAIT_AL = ~(r_busy & ~(&w_strobe_al));
`else
    assign WAIT_AL = RST_WAIT_AL;
`endif

endmodule

// File: tb/tb_cpu_blitter_sequencer.sv
// Self-checking bench for cpu_blitter_sequencer: vector table, random blits, busy/reset corner cases.
module tb_cpu_blitter_sequencer;

    localparam int TB_STRIDE = 256;

    logic        CPU_CLOCK;
    logic        FPGA_RESET;
    logic [7:0]  DB;
    logic [5:0]  strobe_al;
    logic [15:0] GFX_ADDR;
    logic        GFX_RD;
    logic [7:0]  GFX_DATA;
    logic [15:0] VRAM_ADDR;
    logic [7:0]  VRAM_DATA;
    logic        VRAM_WE;
    logic        BLIT_BUSY;
    logic        WAIT_AL;

    cpu_blitter_sequencer #(.ROW_STRIDE(16'(TB_STRIDE))) dut (
        .CPU_CLOCK (CPU_CLOCK),
        .FPGA_RESET(FPGA_RESET),
        .DB        (DB),
        .RDL_AL    (strobe_al[0]),
        .RDH_AL    (strobe_al[1]),
        .WRL_AL    (strobe_al[2]),
        .WRH_AL    (strobe_al[3]),
        .XYL_AL    (strobe_al[4]),
        .XYH_AL    (strobe_al[5]),
        .GFX_ADDR  (GFX_ADDR),
        .GFX_RD    (GFX_RD),
        .GFX_DATA  (GFX_DATA),
        .VRAM_ADDR (VRAM_ADDR),
        .VRAM_DATA (VRAM_DATA),
        .VRAM_WE   (VRAM_WE),
        .BLIT_BUSY (BLIT_BUSY),
        .WAIT_AL   (WAIT_AL)
    );

    initial CPU_CLOCK = 1'b0;
    always #5 CPU_CLOCK = ~CPU_CLOCK;

    function automatic logic [7:0] rom_fn(input logic [15:0] a);
        return a[7:0] ^ {a[11:8], a[15:12]} ^ 8'hA5;
    endfunction

    // Synchronous graphics ROM: data valid the cycle after the read request.
    logic [7:0] rom_q = 8'h00;
    always @(posedge CPU_CLOCK) if (GFX_RD) rom_q <= rom_fn(GFX_ADDR);
    assign GFX_DATA = rom_q;

    logic [23:0] wr_q[$];
    logic [15:0] rd_q[$];
    int busy_cnt = 0;
    int overlap_cnt = 0;
    int gate_viol = 0;

    always @(negedge CPU_CLOCK) begin
        if (VRAM_WE === 1'b1) wr_q.push_back({VRAM_ADDR, VRAM_DATA});
        if (GFX_RD === 1'b1) rd_q.push_back(GFX_ADDR);
        if (BLIT_BUSY === 1'b1) busy_cnt++;
        if (GFX_RD === 1'b1 && VRAM_WE === 1'b1) overlap_cnt++;
        if (GFX_RD === 1'b0 && GFX_ADDR !== 16'h0) gate_viol++;
        if (VRAM_WE === 1'b0 && (VRAM_ADDR !== 16'h0 || VRAM_DATA !== 8'h0)) gate_viol++;
    end

    int n_tests = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge CPU_CLOCK);
        #1;
    endtask

    task automatic wr_reg(input int sel, input logic [7:0] d);
        DB = d;
        strobe_al[sel] = 1'b0;
        step();
        strobe_al[sel] = 1'b1;
        DB = 8'h00;
    endtask

    task automatic program_regs(input logic [15:0] src, input logic [15:0] dst, input logic [7:0] w);
        wr_reg(0, src[7:0]);
        wr_reg(1, src[15:8]);
        wr_reg(2, dst[7:0]);
        wr_reg(3, dst[15:8]);
        wr_reg(4, w);
    endtask

    // Trigger via XYH and check the t+1 / t+2 timing of the first read and write.
    task automatic start_blit(input string tag, input logic [15:0] src, input logic [15:0] dst,
                              input logic [7:0] h);
        wr_q.delete();
        rd_q.delete();
        busy_cnt = 0;
        DB = h;
        strobe_al[5] = 1'b0;
        step();
        strobe_al[5] = 1'b1;
        DB = 8'h00;
        check({tag, "_busy_t1"}, BLIT_BUSY, 1);
        check({tag, "_rd_t1"}, GFX_RD, 1);
        check({tag, "_gfxaddr_t1"}, GFX_ADDR, src);
        step();
        check({tag, "_we_t2"}, VRAM_WE, 1);
        check({tag, "_vaddr_t2"}, VRAM_ADDR, dst);
        check({tag, "_vdata_t2"}, VRAM_DATA, rom_fn(src));
    endtask

    // Wait out the blit and compare every read/write against the rectangle model.
    task automatic finish_blit(input string tag, input logic [15:0] src, input logic [15:0] dst,
                               input logic [7:0] w, input logic [7:0] h);
        int n;
        int exp_n;
        int idx;
        int mism;
        logic [15:0] ea;
        logic [15:0] sa;
        n = 0;
        while (BLIT_BUSY === 1'b1 && n < 70000) begin
            step();
            n++;
        end
        check({tag, "_done"}, BLIT_BUSY, 0);
        exp_n = (int'(w) + 1) * (int'(h) + 1);
        check({tag, "_busy_cycles"}, busy_cnt, 2 * exp_n);
        check({tag, "_nwrites"}, wr_q.size(), exp_n);
        check({tag, "_nreads"}, rd_q.size(), exp_n);
        idx = 0;
        mism = 0;
        for (int r = 0; r <= int'(h); r++) begin
            for (int c = 0; c <= int'(w); c++) begin
                ea = dst + 16'(r * TB_STRIDE) + 16'(c);
                sa = src + 16'(idx);
                if (idx < wr_q.size() && wr_q[idx] !== {ea, rom_fn(sa)}) mism++;
                if (idx < rd_q.size() && rd_q[idx] !== sa) mism++;
                idx++;
            end
        end
        check({tag, "_content_mismatches"}, mism, 0);
        $display("[TB] blit %s src=%04h dst=%04h w=%0d h=%0d writes=%0d busy=%0d",
                 tag, src, dst, w, h, wr_q.size(), busy_cnt);
    endtask

    typedef struct {
        logic [15:0] src;
        logic [15:0] dst;
        logic [7:0]  w;
        logic [7:0]  h;
        int          exp_busy;
        logic [15:0] exp_last_addr;
    } vec_t;

    vec_t vecs[5];

    initial begin
        logic [15:0] rs;
        logic [15:0] rd;
        logic [7:0]  rw;
        logic [7:0]  rh;
        int          n;
        int          wviol;
        logic [31:0] last_addr;

        vecs[0] = '{16'h1000, 16'h0000, 8'd1, 8'd1, 8,  16'h0101};
        vecs[1] = '{16'h0040, 16'h1234, 8'd0, 8'd0, 2,  16'h1234};
        vecs[2] = '{16'hFFFF, 16'hFFFF, 8'd1, 8'd0, 4,  16'h0000};
        vecs[3] = '{16'h0200, 16'h4010, 8'd2, 8'd1, 12, 16'h4112};
        vecs[4] = '{16'h7F00, 16'h8000, 8'd0, 8'd2, 6,  16'h8200};

        FPGA_RESET = 1'b1;
        strobe_al  = 6'h3F;
        DB         = 8'h00;
        repeat (3) step();
        check("rst_busy", BLIT_BUSY, 0);
        check("rst_gfx_rd", GFX_RD, 0);
        check("rst_vram_we", VRAM_WE, 0);
        check("rst_gfx_addr", GFX_ADDR, 0);
        check("rst_vram_addr", VRAM_ADDR, 0);
        check("rst_vram_data", VRAM_DATA, 0);
        check("rst_wait", WAIT_AL, 1);
        FPGA_RESET = 1'b0;
        step();

        for (int i = 0; i < 5; i++) begin
            program_regs(vecs[i].src, vecs[i].dst, vecs[i].w);
            start_blit($sformatf("vec%0d", i), vecs[i].src, vecs[i].dst, vecs[i].h);
            finish_blit($sformatf("vec%0d", i), vecs[i].src, vecs[i].dst, vecs[i].w, vecs[i].h);
            check($sformatf("vec%0d_busy_tbl", i), busy_cnt, vecs[i].exp_busy);
            last_addr = (wr_q.size() > 0) ? {16'h0, wr_q[wr_q.size() - 1][23:8]} : 32'hFFFF_FFFF;
            check($sformatf("vec%0d_last_addr", i), last_addr, {16'h0, vecs[i].exp_last_addr});
            step();
        end

        // Retrigger with XYH only: SRC, DST and W must be unchanged by the previous blit.
        start_blit("repeat", vecs[4].src, vecs[4].dst, 8'd1);
        finish_blit("repeat", vecs[4].src, vecs[4].dst, vecs[4].w, 8'd1);
        step();

        for (int i = 0; i < 12; i++) begin
            rs = 16'($urandom);
            rd = 16'($urandom);
            rw = 8'($urandom_range(0, 7));
            rh = 8'($urandom_range(0, 5));
            program_regs(rs, rd, rw);
            start_blit($sformatf("rand%0d", i), rs, rd, rh);
            finish_blit($sformatf("rand%0d", i), rs, rd, rw, rh);
            step();
        end

        // Busy-time write to WRL with 0x55.
        program_regs(16'h3000, 16'h2000, 8'd3);
        start_blit("busywr", 16'h3000, 16'h2000, 8'd3);
        repeat (3) step();
        DB = 8'h55;
        strobe_al[2] = 1'b0;
        #1;
`ifdef BLIT_WAIT_EN
        check("busywr_wait_low", WAIT_AL, 0);
        n = 0;
        wviol = 0;
        while (BLIT_BUSY === 1'b1 && n < 2000) begin
            if (WAIT_AL !== 1'b0) wviol++;
            step();
            n++;
        end
        check("busywr_idle_reached", BLIT_BUSY, 0);
        check("busywr_wait_held", wviol, 0);
        check("busywr_wait_released", WAIT_AL, 1);
        step();
        strobe_al[2] = 1'b1;
        DB = 8'h00;
        finish_blit("busywr", 16'h3000, 16'h2000, 8'd3, 8'd3);
        step();
        start_blit("after_busywr", 16'h3000, 16'h2055, 8'd0);
        finish_blit("after_busywr", 16'h3000, 16'h2055, 8'd3, 8'd0);
`else
        check("busywr_wait_high", WAIT_AL, 1);
        step();
        check("busywr_wait_high2", WAIT_AL, 1);
        strobe_al[2] = 1'b1;
        DB = 8'h00;
        finish_blit("busywr", 16'h3000, 16'h2000, 8'd3, 8'd3);
        step();
        start_blit("after_busywr", 16'h3000, 16'h2000, 8'd0);
        finish_blit("after_busywr", 16'h3000, 16'h2000, 8'd3, 8'd0);
`endif
        step();

        // Reset in the middle of a 4x4 blit.
        program_regs(16'h1234, 16'h5000, 8'd3);
        start_blit("abort", 16'h1234, 16'h5000, 8'd3);
        repeat (4) step();
        FPGA_RESET = 1'b1;
        step();
        check("abort_busy", BLIT_BUSY, 0);
        check("abort_we", VRAM_WE, 0);
        check("abort_rd", GFX_RD, 0);
        check("abort_vaddr", VRAM_ADDR, 0);
        check("abort_wait", WAIT_AL, 1);
        FPGA_RESET = 1'b0;
        step();
        check("abort_we_after", VRAM_WE, 0);
        // Registers were cleared: an XYH-only trigger copies from 0 to 0 with W=0.
        start_blit("postrst", 16'h0000, 16'h0000, 8'd1);
        finish_blit("postrst", 16'h0000, 16'h0000, 8'd0, 8'd1);
        step();
        program_regs(16'h0A00, 16'h6000, 8'd2);
        start_blit("postrst2", 16'h0A00, 16'h6000, 8'd2);
        finish_blit("postrst2", 16'h0A00, 16'h6000, 8'd2, 8'd2);
        step();

        check("rd_we_overlap", overlap_cnt, 0);
        check("addr_data_gating", gate_viol, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
